// File: rtl/sum_arb_pkg.sv
// Shared types and constants for the round-robin sum arbiter.
// Statistics counters are built only when SUM_ARB_STATS_EN is defined.
package sum_arb_pkg;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   localparam int STAT_W = 16;

   // Index width for n requesters; a lone requester still needs one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dff.sv
// Enabled D flip-flop bank with synchronous active-low clear.
module dff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Storage register, loaded only when en is high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= {W{1'b0}};
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin pick: first set bit of req at or above ptr, wrapping to 0.
module rr_grant #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx
);

   logic found_s;
   logic hit_s;

   // Two passes: indices >= ptr first, then the wrapped indices below ptr.
   always_comb begin
      grant     = {N{1'b0}};
      grant_idx = {PW{1'b0}};
      found_s   = 1'b0;
      hit_s     = 1'b0;
      for (int i = 0; i < N; i++) begin
         hit_s     = req[i] && !found_s && (i >= int'(ptr));
         grant[i]  = grant[i] | hit_s;
         grant_idx = hit_s ? PW'(i) : grant_idx;
         found_s   = found_s | hit_s;
      end
      for (int i = 0; i < N; i++) begin
         hit_s     = req[i] && !found_s && (i < int'(ptr));
         grant[i]  = grant[i] | hit_s;
         grant_idx = hit_s ? PW'(i) : grant_idx;
         found_s   = found_s | hit_s;
      end
   end

endmodule

// File: rtl/sum.sv
// Shared registered adder: y <= a + b (zero-extended, no overflow loss) when en is high.
module sum #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   y
);

   // Result register, cleared by the synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         y <= {(WIDTH+1){1'b0}};
      end else if (en) begin
         y <= {1'b0, a} + {1'b0, b};
      end
   end

endmodule

// File: rtl/sum_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Define SUM_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module sum_arbiter
   import sum_arb_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH:0]           res_data,
   output logic [ID_W-1:0]          res_id
`ifdef SUM_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

   state_t             state_r;
   state_t             state_nx_s;
   logic [ID_W-1:0]    ptr_r;
   logic [ID_W-1:0]    ptr_nx_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [ID_W-1:0]    grant_idx_s;
   logic               stall_s;
   logic               acc_s;
   logic [WIDTH-1:0]   a_sel_s;
   logic [WIDTH-1:0]   b_sel_s;

   assign res_valid = (state_r == S_FULL);

   rr_grant #(
      .N  (NUM_REQ),
      .PW (ID_W)
   ) u_rr_grant (
      .req       (req_valid),
      .ptr       (ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   // Handshake: a held, unconsumed result blocks every grant; reset blocks them too.
   always_comb begin
      stall_s   = res_valid & ~res_ready;
      req_ready = (rst && !stall_s) ? grant_s : {NUM_REQ{1'b0}};
      acc_s     = |(req_valid & req_ready);
      a_sel_s   = req_a[grant_idx_s*WIDTH +: WIDTH];
      b_sel_s   = req_b[grant_idx_s*WIDTH +: WIDTH];
      ptr_nx_s  = (grant_idx_s == ID_W'(NUM_REQ-1)) ? {ID_W{1'b0}} : grant_idx_s + ID_W'(1);
   end

   // Output-slot state: a new acceptance always (re)fills the slot.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_EMPTY: state_nx_s = acc_s ? S_FULL : S_EMPTY;
         S_FULL: begin
            if (acc_s) begin
               state_nx_s = S_FULL;
            end else if (res_ready) begin
               state_nx_s = S_EMPTY;
            end else begin
               state_nx_s = S_FULL;
            end
         end
         default: state_nx_s = S_EMPTY;
      endcase
   end

   // State and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= S_EMPTY;
         ptr_r   <= {ID_W{1'b0}};
      end else begin
         state_r <= state_nx_s;
         if (acc_s) begin
            ptr_r <= ptr_nx_s;
         end
      end
   end

   sum #(
      .WIDTH (WIDTH)
   ) u_sum (
      .clk (clk),
      .rst (rst),
      .en  (acc_s),
      .a   (a_sel_s),
      .b   (b_sel_s),
      .y   (res_data)
   );

   dff #(
      .W (ID_W)
   ) u_res_id (
      .clk (clk),
      .rst (rst),
      .en  (acc_s),
      .d   (grant_idx_s),
      .q   (res_id)
   );

`ifdef SUM_ARB_STATS_EN
   logic [STAT_W-1:0] cnt_r [NUM_REQ];

   // Saturating acceptance counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_r[i] <= {STAT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i] && (cnt_r[i] != {STAT_W{1'b1}})) begin
               cnt_r[i] <= cnt_r[i] + STAT_W'(1);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign grant_cnt[g*STAT_W +: STAT_W] = cnt_r[g];
   end
`endif

endmodule

// File: tb/tb_sum_arbiter.sv
// Table-driven bench for sum_arbiter (WIDTH=8, NUM_REQ=4), plus hand-written multi-cycle sequences.
module tb_sum_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        res_valid;
   logic        res_ready;
   logic [8:0]  res_data;
   logic [1:0]  res_id;
`ifdef SUM_ARB_STATS_EN
   logic [63:0] grant_cnt;
`endif

   sum_arbiter #(
      .WIDTH   (8),
      .NUM_REQ (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id)
`ifdef SUM_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] a;
      logic [31:0] b;
      logic        rr;
      logic [3:0]  exp_ready;
      logic        exp_valid;
      logic        chk;
      logic [8:0]  exp_data;
      logic [1:0]  exp_id;
   } vec_t;

   vec_t vecs[$];
   int   n_vec;
   int   n_bad;

   // Operand sets: requester i sits in byte i. Sums are 11, 22, 33, 44.
   localparam logic [31:0] OPA = {8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [31:0] OPB = {8'd40, 8'd30, 8'd20, 8'd10};
   localparam logic [31:0] MXA = {8'd255, 8'd3, 8'd2, 8'd1};
   localparam logic [31:0] MXB = {8'd255, 8'd30, 8'd20, 8'd10};
   localparam logic [31:0] SGA = {8'd4, 8'd200, 8'd2, 8'd1};
   localparam logic [31:0] SGB = {8'd40, 8'd100, 8'd20, 8'd10};

   task automatic add(input logic r, input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic rr, input logic [3:0] er, input logic ev, input logic ck,
                      input logic [8:0] ed, input logic [1:0] ei);
      vec_t t;
      t.rst = r; t.valid = v; t.a = a; t.b = b; t.rr = rr;
      t.exp_ready = er; t.exp_valid = ev; t.chk = ck; t.exp_data = ed; t.exp_id = ei;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One cycle: drive at negedge, check req_ready just before posedge, outputs just after.
   task automatic run_cycle(input string tag, input vec_t t);
      @(negedge clk);
      rst = t.rst; req_valid = t.valid; req_a = t.a; req_b = t.b; res_ready = t.rr;
      #4;
      check({tag, ".req_ready"}, 32'(req_ready), 32'(t.exp_ready));
      @(posedge clk);
      #1;
      n_vec++;
      check({tag, ".res_valid"}, 32'(res_valid), 32'(t.exp_valid));
      if (t.chk) begin
         check({tag, ".res_data"}, 32'(res_data), 32'(t.exp_data));
         check({tag, ".res_id"}, 32'(res_id), 32'(t.exp_id));
      end
   endtask

   initial begin
      vec_t h;
      n_vec = 0;
      n_bad = 0;
      rst = 1'b0; req_valid = 4'b0; req_a = 32'd0; req_b = 32'd0; res_ready = 1'b0;

      //   rst   valid    a    b    rr    ready    vld   chk   data     id
      add(1'b0, 4'b1111, OPA, OPB, 1'b1, 4'b0000, 1'b0, 1'b1, 9'd0,   2'd0);
      add(1'b0, 4'b1111, OPA, OPB, 1'b1, 4'b0000, 1'b0, 1'b1, 9'd0,   2'd0);
      add(1'b1, 4'b0100, SGA, SGB, 1'b1, 4'b0100, 1'b1, 1'b1, 9'd300, 2'd2);
      add(1'b1, 4'b0000, OPA, OPB, 1'b1, 4'b0000, 1'b0, 1'b0, 9'd0,   2'd0);
      add(1'b1, 4'b1000, MXA, MXB, 1'b1, 4'b1000, 1'b1, 1'b1, 9'd510, 2'd3);
      add(1'b1, 4'b1111, OPA, OPB, 1'b1, 4'b0001, 1'b1, 1'b1, 9'd11,  2'd0);
      add(1'b1, 4'b1111, OPA, OPB, 1'b1, 4'b0010, 1'b1, 1'b1, 9'd22,  2'd1);
      add(1'b1, 4'b1111, OPA, OPB, 1'b1, 4'b0100, 1'b1, 1'b1, 9'd33,  2'd2);
      add(1'b1, 4'b1111, OPA, OPB, 1'b1, 4'b1000, 1'b1, 1'b1, 9'd44,  2'd3);
      add(1'b1, 4'b1111, OPA, OPB, 1'b1, 4'b0001, 1'b1, 1'b1, 9'd11,  2'd0);
      add(1'b1, 4'b1111, OPA, OPB, 1'b1, 4'b0010, 1'b1, 1'b1, 9'd22,  2'd1);
      add(1'b1, 4'b1000, OPA, OPB, 1'b1, 4'b1000, 1'b1, 1'b1, 9'd44,  2'd3);
      add(1'b1, 4'b1001, OPA, OPB, 1'b1, 4'b0001, 1'b1, 1'b1, 9'd11,  2'd0);
      add(1'b1, 4'b0100, OPA, OPB, 1'b1, 4'b0100, 1'b1, 1'b1, 9'd33,  2'd2);
      add(1'b1, 4'b1111, OPA, OPB, 1'b0, 4'b0000, 1'b1, 1'b1, 9'd33,  2'd2);
      add(1'b1, 4'b1111, OPA, OPB, 1'b0, 4'b0000, 1'b1, 1'b1, 9'd33,  2'd2);
      add(1'b1, 4'b1111, OPA, OPB, 1'b0, 4'b0000, 1'b1, 1'b1, 9'd33,  2'd2);
      add(1'b1, 4'b1111, OPA, OPB, 1'b1, 4'b1000, 1'b1, 1'b1, 9'd44,  2'd3);
      add(1'b1, 4'b0000, OPA, OPB, 1'b0, 4'b0000, 1'b1, 1'b1, 9'd44,  2'd3);
      add(1'b1, 4'b0000, OPA, OPB, 1'b1, 4'b0000, 1'b0, 1'b1, 9'd44,  2'd3);
      add(1'b1, 4'b0010, OPA, OPB, 1'b0, 4'b0010, 1'b1, 1'b1, 9'd22,  2'd1);
      add(1'b0, 4'b1111, OPA, OPB, 1'b0, 4'b0000, 1'b0, 1'b1, 9'd0,   2'd0);
      add(1'b1, 4'b1111, OPA, OPB, 1'b1, 4'b0001, 1'b1, 1'b1, 9'd11,  2'd0);
      add(1'b1, 4'b0000, OPA, OPB, 1'b1, 4'b0000, 1'b0, 1'b0, 9'd0,   2'd0);

      foreach (vecs[i]) begin
         run_cycle($sformatf("v%0d", i), vecs[i]);
      end

      // Lone requester 2 held valid: granted every cycle with no bubbles.
      h.rst = 1'b1; h.valid = 4'b0100; h.a = OPA; h.b = OPB; h.rr = 1'b1;
      h.exp_ready = 4'b0100; h.exp_valid = 1'b1; h.chk = 1'b1; h.exp_data = 9'd33; h.exp_id = 2'd2;
      for (int k = 0; k < 5; k++) begin
         run_cycle($sformatf("lone%0d", k), h);
      end

`ifdef SUM_ARB_STATS_EN
      // 70000 back-to-back grants to requester 1 saturate its counter.
      @(negedge clk);
      req_valid = 4'b0010; res_ready = 1'b1;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      req_valid = 4'b0000;
      n_vec++;
      check("cnt1_sat", 32'(grant_cnt[16 +: 16]), 32'd65535);
      check("cnt0", 32'(grant_cnt[0 +: 16]), 32'd1);
      check("cnt2", 32'(grant_cnt[32 +: 16]), 32'd5);
      check("cnt3", 32'(grant_cnt[48 +: 16]), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sum_arbiter.md
# sum_arbiter

Round-robin arbiter that shares one registered adder (the common `sum` unit) among `NUM_REQ` requesters in the pixel-processing datapath. Each requester offers an operand pair with a valid/ready handshake. The arbiter grants at most one requester per cycle and drives the shared adder. It returns the `WIDTH+1`-bit sum, tagged with the requester index, on a single output channel that supports backpressure. It replaces per-stage private adders where the stages are not all active every cycle.

## Interface
- `WIDTH`, 8, operand width; the result is `WIDTH+1` bits.
- `NUM_REQ`, 4, number of requesters; legal range 2..16.
- `ID_W`, `$clog2(NUM_REQ)`, derived; do not override.

- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester operand valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit is set.
- `req_a`  in  `NUM_REQ*WIDTH`  operand A; requester i occupies slice `[i*WIDTH +: WIDTH]`.
- `req_b`  in  `NUM_REQ*WIDTH`  operand B; same packing as `req_a`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  downstream accept.
- `res_data`  out  `WIDTH+1`  the sum `a+b`, zero-extended, with no overflow loss.
- `res_id`  out  `ID_W`  index of the requester that produced `res_data`.
- `grant_cnt`  out  `NUM_REQ*16`  present only with `SUM_ARB_STATS_EN`.

## Operation
- **Stall:** `stall = res_valid & ~res_ready`.
- **Grant:** `grant` is the first requester with `req_valid` set, searching from `ptr` upward and wrapping modulo `NUM_REQ`.
  - `req_ready = grant & ~stall`; this is combinational.
  - Acceptance happens when `req_valid[i] & req_ready[i]`.
- **Operand hold:** a requester keeps `req_valid`, `req_a` and `req_b` stable until it is accepted. Dropping valid before acceptance is legal; that requester is then simply skipped.
- **Pointer:** on acceptance by requester i, `ptr <= (i+1) mod NUM_REQ`. With no acceptance, `ptr` holds.
- **Adder drive:**
  - Adder `en` = acceptance this cycle.
  - The adder inputs are the granted requester's operands, selected by a mux.
  - `res_id` is registered alongside the adder, under the same enable.
- **FSM state `S_EMPTY` (`res_valid=0`):**
  - Acceptance -> `S_FULL`.
  - Otherwise stay in `S_EMPTY`.
- **FSM state `S_FULL` (`res_valid=1`):**
  - `res_ready=0`: stay; no grant; adder and `res_id` hold.
  - `res_ready=1` with a new acceptance in the same cycle: stay in `S_FULL`; the new result replaces the old one.
  - `res_ready=1` with no acceptance -> `S_EMPTY`.
- In `S_EMPTY`, `res_data` and `res_id` hold their last values; they are don't-care to the consumer.
- **Arithmetic:** unsigned; `res_data = {1'b0,a} + {1'b0,b}`. All-ones operands give `2^(WIDTH+1)-2`.

## Timing
- Latency: a request accepted in cycle N produces `res_valid` in cycle N+1.
- Throughput: 1 result/cycle while `res_ready` stays high. With every requester valid, grants are perfectly round-robin.
- `req_ready` is a combinational function of `req_valid`, `ptr`, `res_valid` and `res_ready`. There is no combinational path from `req_a` or `req_b` to any output.
- Reset values (`rst=0` at a clock edge):
  - `res_valid=0`, `res_data=0`, `res_id=0`, `ptr=0`, state `S_EMPTY`, all `grant_cnt` = 0.
  - While `rst=0`, `req_ready` = 0.
- Reset mid-operation: any held or in-flight result is discarded; `res_valid` is 0 in the cycle after the reset edge.
- `ptr` wraps from `NUM_REQ-1` to 0.
- A single active requester is granted every cycle, as long as there is no stall.

## Configuration
- **`SUM_ARB_STATS_EN` defined:**
  - Adds `grant_cnt`: one 16-bit counter per requester.
  - A counter increments on each acceptance by its requester and saturates at `16'hFFFF`.
  - Counters are cleared by reset only.
- **`SUM_ARB_STATS_EN` undefined:** the port and the counters are absent; behaviour is otherwise identical.

## Structure
- **Shared package `sum_arb_pkg`:**
  - FSM state encodings `S_EMPTY=1'b0`, `S_FULL=1'b1`.
  - `STAT_W=16`.
  - An id-width helper function.
- **Sub-module `rr_grant`:** combinational round-robin priority pick, with inputs `req` and `ptr` and outputs one-hot `grant` and `grant_idx`.
- **Datapath:** the existing `sum` unit, instantiated once with the arbiter's `WIDTH`. The `res_id` register is a separate `dff` with width `ID_W` and the same enable.

## Test plan
- **Reset:** `rst=0` for 2 cycles with all requests valid -> `req_ready=0`, `res_valid=0`, `res_data=0`, `res_id=0`.
- **Single request:** requester 2 only, a=200, b=100, `res_ready=1` -> accepted in cycle 0; cycle 1 shows `res_valid=1`, `res_data=300`, `res_id=2`.
- **Round-robin:** all 4 requesters valid continuously, `res_ready=1` -> `res_id` sequence 0,1,2,3,0,1 with one result per cycle.
- **Backpressure:** hold `res_ready=0` for 3 cycles while `S_FULL` -> `res_data` and `res_id` stable, `req_ready` all 0, `ptr` unchanged. Release -> the next grant follows in the same cycle.
- **Overflow and wrap:**
  - a=255, b=255 -> `res_data=510`.
  - Requester 3 is granted, then only requester 0 is valid -> requester 0 is granted next.
- **Reset mid-operation and stats:** `rst=0` while `S_FULL` -> `res_valid=0` next cycle. With `SUM_ARB_STATS_EN` defined, 70000 grants to requester 1 -> `grant_cnt[1]=65535`.
